half_adder_arb: RTL and testbench
=================================

HALF_ADDER_ARB -- requirements
Module: half_adder_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters (range 2..8).
REQ-002 Parameter DW, default 9, sets the operand width; the sum width is DW+1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-requester operand-pair valid.
REQ-006 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-007 req_a, req_b  in  NUM_REQ*DW each  packed operands, requester i at bits [i*DW +: DW].
REQ-008 rsp_valid  out  NUM_REQ  per-requester result valid.
REQ-009 rsp_ready  in  NUM_REQ  per-requester result accept.
REQ-010 rsp_sum  out  NUM_REQ*(DW+1)  packed results, requester i at bits [i*(DW+1) +: DW+1].
REQ-011 add_in_valid  out  1  issue strobe to the shared adder.
REQ-012 add_data_in0, add_data_in1  out  DW each  operands to the adder.
REQ-013 add_out_valid  in  1  adder result strobe.
REQ-014 add_data_out  in  DW+1  adder sum.
REQ-015 busy  out  1  any operation pending.
REQ-016 err  out  1  sticky: unexpected add_out_valid.

Function
REQ-017 Requester i SHALL be eligible when req_valid[i]=1, pending[i]=0 and rsp_valid[i]=0, using registered state only.
REQ-018 Arbitration SHALL be round-robin: search from pointer ptr upward with wrap, and grant the first eligible index.
REQ-019 req_ready SHALL be asserted combinationally for the granted index only; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-020 On a transfer to i, ptr SHALL become (i+1) mod NUM_REQ; with no transfer, ptr SHALL hold.
REQ-021 Issue stage: a transfer at edge T SHALL produce add_in_valid=1 with registered operands during cycle T+1; otherwise add_in_valid=0 and the operands hold.
REQ-022 A 2-stage tag pipeline (valid + index) SHALL track the issue, aligned so the tag is present when add_out_valid is expected (cycle T+2).
REQ-023 When add_out_valid=1 and the tag is valid, add_data_out SHALL be captured into slot[tag]; rsp_valid[tag] SHALL be set and pending[tag] cleared at the next edge (rsp_valid visible from cycle T+3).
REQ-024 The adder is assumed to have fixed 1-cycle latency; when add_out_valid=1 with no valid tag, the data SHALL be dropped and err set, held until reset.
REQ-025 When a valid tag is present but add_out_valid=0, the tag SHALL be discarded, pending[tag] cleared, and err set.
REQ-026 rsp_valid[i] SHALL clear on rsp_valid[i] and rsp_ready[i] both high; requester i becomes eligible again no earlier than the following cycle.
REQ-027 rsp_sum[i] SHALL hold stable while rsp_valid[i]=1; the full DW+1 width is used with no truncation.
REQ-028 Throughput SHALL be one issue per cycle across different requesters, and at most one outstanding operation per requester.
REQ-029 busy SHALL equal OR(pending) | OR(tag valids) | add_in_valid.

Reset
REQ-030 While rst_n=0: req_ready=0, rsp_valid=0, rsp_sum=0, add_in_valid=0, add operands=0, ptr=0, pending=0, tag valids=0, err=0, busy=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight work; an add_out_valid in the first cycle after release SHALL set err.

Structure
REQ-032 A shared package half_adder_pkg SHALL hold DW default, NUM_REQ default, and the tag struct (valid, index of width $clog2(NUM_REQ)).
REQ-033 The round-robin grant logic SHALL be the single sub-module rr_arbiter (inputs: eligible vector and ptr; output: one-hot grant).

Verification
REQ-034 Single requester: req0 a=9'h1FF, b=9'h001 accepted at T -> add_in_valid at T+1, rsp_valid[0] at T+3 with rsp_sum[0]=10'h200.
REQ-035 All four requesters valid at once from reset -> grants in order 0,1,2,3 on consecutive cycles; four results each delivered 3 cycles after their own grant.
REQ-036 Backpressure: rsp_ready[1]=0 for 10 cycles with req_valid[1] held -> no second grant to 1 and rsp_sum[1] stable; other requesters continue to be served.
REQ-037 Fairness: requesters 0 and 2 continuously valid with all rsp_ready=1 -> grants alternate 0,2,0,2 and neither requester waits more than NUM_REQ cycles.
REQ-038 Spurious add_out_valid injected with no tag -> err=1 sticky, no rsp_valid change; rst_n pulse clears err.
REQ-039 rst_n asserted one cycle after a grant -> all outputs 0 immediately; no rsp_valid after release.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared definitions for the arbitrated half-adder front end: default sizes and
// the tag carried alongside each operation through the shared adder.
package half_adder_pkg;

  localparam int DW_DEFAULT      = 9;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int NUM_REQ_MAX     = 8;

  // Index sized for the largest supported requester count so one tag type fits every build.
  localparam int IDX_W = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/half_adder_arb_rr_arbiter.sv
// Round-robin grant: searches upward from ptr with wrap-around and grants the
// first eligible requester as a one-hot vector (all zero when none is eligible).
module rr_arbiter
  import half_adder_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  // Outer loop walks the priority order; inner loop keeps every bit select constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && eligible[j] && (j == (int'(ptr) + k) % NUM_REQ)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/half_adder_arb.sv
// Shares one fixed 1-cycle-latency adder among NUM_REQ requesters: round-robin issue,
// a two-stage tag pipeline to route each sum back, and per-requester result slots.
module half_adder_arb
  import half_adder_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int DW      = DW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DW-1:0]     req_a,
  input  logic [NUM_REQ*DW-1:0]     req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*(DW+1)-1:0] rsp_sum,
  output logic                      add_in_valid,
  output logic [DW-1:0]             add_data_in0,
  output logic [DW-1:0]             add_data_in1,
  input  logic                      add_out_valid,
  input  logic [DW:0]               add_data_out,
  output logic                      busy,
  output logic                      err
);

  localparam int SW = DW + 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] pending, eligible, grant;
  logic [NUM_REQ-1:0] pending_nxt, rsp_valid_nxt;
  logic [DW-1:0]      sel_a, sel_b;
  logic               any_xfer, slot_write, err_nxt;
  tag_t               tag_s1, tag_s2;

  assign eligible = req_valid & ~pending & ~rsp_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

  // The grant only targets requesters with req_valid high, so ready alone marks the transfer.
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign any_xfer  = |(req_valid & req_ready);

  always_comb begin
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        grant_idx = IDX_W'(i);
        sel_a     = req_a[i*DW +: DW];
        sel_b     = req_b[i*DW +: DW];
      end
    end
  end

  // A tag reaching stage 2 must meet its sum; either side showing up alone is an error.
  always_comb begin
    pending_nxt   = pending | req_ready;
    rsp_valid_nxt = rsp_valid & ~rsp_ready;
    slot_write    = 1'b0;
    err_nxt       = err;
    if (tag_s2.valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_s2.index == IDX_W'(i)) begin
          pending_nxt[i] = 1'b0;
          if (add_out_valid) rsp_valid_nxt[i] = 1'b1;
        end
      end
      slot_write = add_out_valid;
      if (!add_out_valid) err_nxt = 1'b1;
    end else if (add_out_valid) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      pending      <= '0;
      rsp_valid    <= '0;
      rsp_sum      <= '0;
      add_in_valid <= 1'b0;
      add_data_in0 <= '0;
      add_data_in1 <= '0;
      tag_s1       <= '0;
      tag_s2       <= '0;
      err          <= 1'b0;
    end else begin
      add_in_valid <= any_xfer;
      if (any_xfer) begin
        add_data_in0 <= sel_a;
        add_data_in1 <= sel_b;
        ptr          <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      tag_s1    <= '{valid: any_xfer, index: grant_idx};
      tag_s2    <= tag_s1;
      pending   <= pending_nxt;
      rsp_valid <= rsp_valid_nxt;
      err       <= err_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (slot_write && tag_s2.index == IDX_W'(i)) rsp_sum[i*SW +: SW] <= add_data_out;
      end
    end
  end

  assign busy = (|pending) | tag_s1.valid | tag_s2.valid | add_in_valid;

endmodule

// File: tb/tb_half_adder_arb.sv
// Scoreboard bench for half_adder_arb: a behavioural 1-cycle adder, grants logged
// with expected sums, and results checked for value, routing and latency.
module tb_half_adder_arb;

  localparam int NR = 4;
  localparam int DW = 9;
  localparam int SW = DW + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR*SW-1:0]  rsp_sum;
  logic              add_in_valid, add_out_valid;
  logic [DW-1:0]     add_data_in0, add_data_in1;
  logic [SW-1:0]     add_data_out;
  logic              busy, err;

  typedef struct {
    int            idx;
    logic [SW-1:0] sum;
    int            cyc;
  } exp_t;

  exp_t          expQ[$];
  int            grantLog[$];
  int            grantCyc[$];
  int            testCount = 0;
  int            failCount = 0;
  int            cyc = 0;
  logic [NR-1:0] dropMask = '1;
  logic [NR-1:0] xferSeen = '0;
  logic [NR-1:0] prevValid = '0;
  logic [NR-1:0] prevHs = '0;
  logic [NR*SW-1:0] prevSum = '0;
  logic          adderEn = 1'b1;
  logic          inject = 1'b0;
  logic [SW-1:0] injData = '0;
  logic          sV = 1'b0;
  logic [SW-1:0] sSum = '0;

  always #5 clk = ~clk;

  half_adder_arb #(.NUM_REQ(NR), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sum       (rsp_sum),
    .add_in_valid  (add_in_valid),
    .add_data_in0  (add_data_in0),
    .add_data_in1  (add_data_in1),
    .add_out_valid (add_out_valid),
    .add_data_out  (add_data_out),
    .busy          (busy),
    .err           (err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req_valid[idx]      = 1'b1;
  endtask

  // Advance to just after the next rising edge, retiring requests that were accepted.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(xferSeen & dropMask);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) stepCycle();
    expQ.delete();
    rst_n = 1'b1;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Adder model: one cycle from issue to result, optionally silenced or overridden.
  always @(negedge clk) begin
    sV   = add_in_valid;
    sSum = SW'(add_data_in0) + SW'(add_data_in1);
  end

  always @(posedge clk) begin
    #1;
    add_out_valid = (sV && adderEn) || inject;
    add_data_out  = inject ? injData : sSum;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      xferSeen  = '0;
      prevValid = '0;
      prevHs    = '0;
    end else begin
      xferSeen = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (xferSeen[i]) begin
          e.idx = i;
          e.sum = SW'(req_a[i*DW +: DW]) + SW'(req_b[i*DW +: DW]);
          e.cyc = cyc;
          expQ.push_back(e);
          grantLog.push_back(i);
          grantCyc.push_back(cyc);
        end
        if (rsp_valid[i] && !prevValid[i]) begin
          if (expQ.size() == 0) begin
            checkOutput("sb_unexpected_rsp", 64'(rsp_valid[i]), 64'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("rsp_index", 64'(i), 64'(e.idx));
            checkOutput("rsp_sum", 64'(rsp_sum[i*SW +: SW]), 64'(e.sum));
            checkOutput("rsp_latency", 64'(cyc - e.cyc), 64'(3));
          end
        end
        if (prevValid[i] && !prevHs[i] && rsp_valid[i])
          checkOutput("rsp_hold", 64'(rsp_sum[i*SW +: SW]), 64'(prevSum[i*SW +: SW]));
      end
      prevHs    = rsp_valid & rsp_ready;
      prevValid = rsp_valid;
      prevSum   = rsp_sum;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int cnt;
    req_valid     = '0;
    req_a         = '0;
    req_b         = '0;
    rsp_ready     = '1;
    add_out_valid = 1'b0;
    add_data_out  = '0;

    // Reset values, with requests present to show ready stays low in reset
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_rsp_sum", 64'(rsp_sum), 64'(0));
    checkOutput("rst_add_in_valid", 64'(add_in_valid), 64'(0));
    checkOutput("rst_operands", 64'({add_data_in0, add_data_in1}), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    req_valid = '0;
    rst_n     = 1'b1;
    stepCycle();

    // Single requester, carry into the top sum bit
    grantLog.delete(); grantCyc.delete();
    applyStimulus(0, 9'h1FF, 9'h001);
    n = 0;
    while (grantLog.size() == 0 && n < 20) begin stepCycle(); n++; end
    checkOutput("single_granted", 64'(grantLog.size()), 64'(1));
    checkOutput("single_issue_valid", 64'(add_in_valid), 64'(1));
    checkOutput("single_issue_ops", 64'({add_data_in0, add_data_in1}), 64'({9'h1FF, 9'h001}));
    checkOutput("single_busy", 64'(busy), 64'(1));
    stepCycle();
    checkOutput("single_not_early", 64'(rsp_valid), 64'(0));
    stepCycle();
    checkOutput("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    checkOutput("single_rsp_sum", 64'(rsp_sum[SW-1:0]), 64'(10'h200));
    repeat (3) stepCycle();
    checkOutput("single_idle_busy", 64'(busy), 64'(0));

    // All four requesters from reset: grants 0,1,2,3 back to back
    doReset();
    grantLog.delete(); grantCyc.delete();
    for (int i = 0; i < NR; i++) applyStimulus(i, 9'(i * 97 + 200), 9'(511 - i * 33));
    repeat (12) stepCycle();
    checkOutput("all4_grants", 64'(grantLog.size()), 64'(4));
    for (int k = 0; k < grantLog.size() && k < 4; k++) begin
      checkOutput("all4_order", 64'(grantLog[k]), 64'(k));
      if (k > 0) checkOutput("all4_consecutive", 64'(grantCyc[k] - grantCyc[k-1]), 64'(1));
    end

    // Backpressure on requester 1 while 0 and 2 keep streaming
    dropMask  = '0;
    rsp_ready = 4'b1101;
    grantLog.delete(); grantCyc.delete();
    applyStimulus(0, 9'h011, 9'h022);
    applyStimulus(1, 9'h0F3, 9'h1AB);
    applyStimulus(2, 9'h100, 9'h0FF);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin stepCycle(); n++; end
    cnt = grantLog.size();
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput("bp_hold_valid", 64'(rsp_valid[1]), 64'(1));
    end
    checkOutput("bp_sum1", 64'(rsp_sum[SW +: SW]), 64'(SW'(9'h0F3) + SW'(9'h1AB)));
    n = 0;
    for (int k = 0; k < grantLog.size(); k++) if (grantLog[k] == 1) n++;
    checkOutput("bp_single_grant1", 64'(n), 64'(1));
    checkOutput("bp_others_served", 64'(grantLog.size() - cnt >= 2), 64'(1));
    req_valid = '0;
    rsp_ready = '1;
    dropMask  = '1;
    repeat (8) stepCycle();
    checkOutput("bp_drained", 64'(expQ.size()), 64'(0));

    // Fairness between requesters 0 and 2
    doReset();
    dropMask = '0;
    grantLog.delete(); grantCyc.delete();
    applyStimulus(0, 9'h0A5, 9'h05A);
    applyStimulus(2, 9'h1C3, 9'h03C);
    repeat (24) stepCycle();
    req_valid = '0;
    dropMask  = '1;
    repeat (8) stepCycle();
    checkOutput("fair_enough_grants", 64'(grantLog.size() >= 8), 64'(1));
    for (int k = 1; k < grantLog.size(); k++) begin
      checkOutput("fair_alternate", 64'(grantLog[k]), 64'((grantLog[k-1] == 0) ? 2 : 0));
      if (k > 1) checkOutput("fair_gap", 64'(grantCyc[k] - grantCyc[k-2]), 64'(4));
    end

    // Spurious adder result with nothing in flight
    checkOutput("spur_err_before", 64'(err), 64'(0));
    @(negedge clk);
    inject  = 1'b1;
    injData = 10'h155;
    @(negedge clk);
    inject = 1'b0;
    repeat (2) stepCycle();
    checkOutput("spur_err", 64'(err), 64'(1));
    checkOutput("spur_no_rsp", 64'(rsp_valid), 64'(0));
    repeat (5) stepCycle();
    checkOutput("spur_err_sticky", 64'(err), 64'(1));
    doReset();
    checkOutput("rst_clears_err", 64'(err), 64'(0));

    // Issued operation whose result never arrives
    adderEn = 1'b0;
    applyStimulus(3, 9'h003, 9'h004);
    repeat (6) stepCycle();
    checkOutput("lost_err", 64'(err), 64'(1));
    checkOutput("lost_no_rsp", 64'(rsp_valid), 64'(0));
    checkOutput("lost_not_busy", 64'(busy), 64'(0));
    checkOutput("lost_sb_left", 64'(expQ.size()), 64'(1));
    expQ.delete();
    adderEn = 1'b1;
    doReset();

    // Reset one cycle after a grant discards the operation
    grantLog.delete(); grantCyc.delete();
    applyStimulus(3, 9'h0AA, 9'h055);
    n = 0;
    while (grantLog.size() == 0 && n < 20) begin stepCycle(); n++; end
    checkOutput("midrst_granted", 64'(grantLog.size()), 64'(1));
    rst_n     = 1'b0;
    req_valid = 4'b1000;
    #1;
    checkOutput("midrst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("midrst_add_in_valid", 64'(add_in_valid), 64'(0));
    checkOutput("midrst_operands", 64'({add_data_in0, add_data_in1}), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    expQ.delete();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    checkOutput("midrst_err", 64'(err), 64'(0));
    checkOutput("end_sb_empty", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
